// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the program store and PC, presents 32-bit words over valid/ready,
// honours the core's skip request and stops on HALT_OP.
module inst_fetch_unit #(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_wdata,
    output logic [31:0]       inst_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              skip,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HALTED} state_t;

    state_t            state, state_nx;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] pc_nx, rd_addr;
    logic [31:0]       rd_word, inst_nx;
    logic              valid_nx, skip_pend, skip_pend_nx, stopped;

    assign stopped = (state == IDLE) || (state == HALTED);
    assign rd_addr = pc_out + ADDR_W'(skip_pend);
    assign rd_word = mem[rd_addr];

    // NOTE: the program store is deliberately left out of reset so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (stopped && prog_we)
            mem[prog_addr] <= prog_wdata;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx     = state;
        pc_nx        = pc_out;
        skip_pend_nx = skip_pend;
        inst_nx      = inst_out;
        valid_nx     = inst_valid;
        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_nx        = start_pc;
                    skip_pend_nx = 1'b0;
                    state_nx     = FETCH;
                end
            end
            FETCH: begin
                // A skip seen here applies to the word after the one being read now.
                skip_pend_nx = skip;
                if (rd_word[31:29] == HALT_OP) begin
                    pc_nx    = rd_addr;
                    state_nx = HALTED;
                end else begin
                    inst_nx  = rd_word;
                    valid_nx = 1'b1;
                    pc_nx    = rd_addr + 1'b1;
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (skip)
                    skip_pend_nx = 1'b1;
                if (inst_ready) begin
                    valid_nx = 1'b0;
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc_out     <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            skip_pend  <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nx;
            pc_out     <= pc_nx;
            inst_out   <= inst_nx;
            inst_valid <= valid_nx;
            skip_pend  <= skip_pend_nx;
            busy       <= (state_nx == FETCH) || (state_nx == PRESENT);
            halted     <= (state_nx == HALTED);
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a word-level reference model predicts every presented
// instruction, the handshake timing, PC, busy/halted, and checks the outputs each cycle.
module tb_inst_fetch_unit;

    localparam int         AW   = 8;
    localparam logic [2:0] HALT = 3'b111;

    logic          clk = 1'b0;
    logic          rst, start, prog_we, inst_ready, skip;
    logic [AW-1:0] start_pc, prog_addr, pc_out;
    logic [31:0]   prog_wdata, inst_out;
    logic          inst_valid, busy, halted;

    always #5 clk = ~clk;

    inst_fetch_unit #(.ADDR_W(AW), .HALT_OP(HALT)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .inst_out(inst_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .skip(skip), .pc_out(pc_out), .busy(busy), .halted(halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: program image, address of the word in flight, and a "skip seen during
    // this word's lifetime" flag that makes the following sequential word disappear.
    logic [31:0]   mem_m [256];
    logic [AW-1:0] maddr, exp_pc;
    logic [31:0]   exp_inst;
    logic          skip_seen, fetch_now, exp_valid, exp_busy, exp_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0; exp_busy = 1'b0; exp_halted = 1'b0;
        exp_pc = '0; exp_inst = '0; fetch_now = 1'b0; skip_seen = 1'b0; maddr = '0;
    endtask

    // One clock: compare outputs at the falling edge, then drive inputs and advance the model.
    task automatic cycle(input logic st, input logic [AW-1:0] spc, input logic we,
                         input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic rdy, input logic sk, input logic do_rst);
        logic [31:0] word;
        @(negedge clk);
        check("valid", inst_valid, exp_valid);
        check("busy", busy, exp_busy);
        check("halted", halted, exp_halted);
        check("pc", pc_out, exp_pc);
        if (exp_valid) check("inst", inst_out, exp_inst);
        if (do_rst) begin
            start = 0; prog_we = 0; skip = 0; inst_ready = 0;
            #2 rst = 1'b1;
            #1;
            check("arst_valid", inst_valid, 0);
            check("arst_pc", pc_out, 0);
            check("arst_inst", inst_out, 0);
            check("arst_busy", busy, 0);
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            return;
        end
        start = st; start_pc = spc; prog_we = we; prog_addr = wa; prog_wdata = wd;
        inst_ready = rdy; skip = sk;
        if (!exp_busy) begin
            if (we) mem_m[wa] = wd;
            if (st) begin
                maddr = spc; skip_seen = 1'b0; fetch_now = 1'b1;
                exp_busy = 1'b1; exp_halted = 1'b0; exp_pc = spc;
            end
        end else if (fetch_now) begin
            fetch_now = 1'b0;
            skip_seen = sk;
            word = mem_m[maddr];
            if (word[31:29] == HALT) begin
                exp_busy = 1'b0; exp_halted = 1'b1; exp_pc = maddr;
            end else begin
                exp_valid = 1'b1; exp_inst = word; exp_pc = maddr + 1'b1;
            end
        end else begin
            skip_seen = skip_seen | sk;
            if (rdy) begin
                maddr = maddr + 1'b1 + AW'(skip_seen);
                skip_seen = 1'b0; exp_valid = 1'b0; fetch_now = 1'b1;
            end
        end
    endtask

    initial begin
        logic          st, we, rdy, sk, rs;
        logic [AW-1:0] spc, wa;
        logic [31:0]   wd;
        rst = 1'b1; start = 0; start_pc = '0; prog_we = 0; prog_addr = '0;
        prog_wdata = '0; inst_ready = 0; skip = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_inst", inst_out, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++)
            cycle(1'b0, '0, 1'b1, AW'(i), $urandom, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 4000; n++) begin
            st  = exp_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
            we  = exp_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
            spc = ($urandom_range(0, 3) == 0) ? AW'(8'hFD + $urandom_range(0, 2)) : AW'($urandom);
            wa  = ($urandom_range(0, 2) == 0) ? (exp_busy ? maddr : spc) : AW'($urandom);
            wd  = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            sk  = ($urandom_range(0, 4) == 0);
            rs  = exp_busy && ($urandom_range(0, 149) == 0);
            cycle(st, spc, we, wa, wd, rdy, sk, rs);
        end

        // Wrap-around: LW at the top address, HALT at 0.
        cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 8'hFF, {3'b000, 5'd1, 5'd0, 3'd0, 16'h0010}, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'h00, {HALT, 29'd0}, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("wrap_halted", halted, 1);
        check("wrap_pc", pc_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
